// File: rtl/laser_tick_table_gen.sv
// Builds per-frame {active, delta_tick} tables from CORDIC theta/tick lookups on each update_mem_i toggle.
// Optional LASER_TICK_TABLE_PIXEL_MASK_EN adds pixel_mask_i, which drives the active bit per column.
module laser_tick_table_gen #(
    parameter int FRAME_COLUMNS_P = 360,
    parameter int LINE_POINTS_P   = 20,
    parameter int FRAME_NUMBER_P  = 5,
    parameter int TICK_W_P        = 16,
    localparam int PASSAGES = FRAME_COLUMNS_P / LINE_POINTS_P,
    localparam int STEP     = FRAME_NUMBER_P * PASSAGES,
    localparam int TOTAL    = FRAME_COLUMNS_P * FRAME_NUMBER_P,
    localparam int THETA_W  = $clog2(TOTAL),
    localparam int ADDR_W   = $clog2(FRAME_COLUMNS_P),
    localparam int FSEL_W   = (FRAME_NUMBER_P > 1) ? $clog2(FRAME_NUMBER_P) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 update_mem_i,
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
    input  logic [FRAME_COLUMNS_P-1:0] pixel_mask_i,
`endif
    output logic                 theta_valid_o,
    output logic [THETA_W-1:0]   theta_o,
    input  logic                 theta_ready_i,
    input  logic                 tick_valid_i,
    input  logic [TICK_W_P-1:0]  tick_i,
    output logic                 we_o,
    output logic [ADDR_W-1:0]    waddr_o,
    output logic [TICK_W_P:0]    wdata_o,
    output logic [FSEL_W-1:0]    mem_sel_o,
    output logic                 mem_updated_o,
    output logic                 done_o,
    output logic                 overrun_o
);
    localparam int EDGE_N = 1 << FSEL_W;

    typedef enum logic [1:0] {S_IDLE, S_EDGE, S_UPDATE, S_DONE} state_t;
    state_t state_q, state_d;

    logic                upd_s1_q, upd_s2_q;
    logic                vld_q, outst_q, kick_q, last_wr_q;
    logic [FSEL_W-1:0]   f_q;
    logic [ADDR_W-1:0]   col_q, p_q, k_q;
    logic [TICK_W_P-1:0] last_q;
    logic [TICK_W_P-1:0] edge_tick_q [EDGE_N];
    logic                we_q, overrun_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic [TICK_W_P:0]   wdata_q;
    logic [FSEL_W-1:0]   msel_q;
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
    logic [FRAME_COLUMNS_P-1:0] mask_q;
`endif

    logic                req, rsp, last_frame, last_col, last_p, active;
    logic [TICK_W_P-1:0] base_tick, corr_tick, delta;

    assign req        = upd_s1_q ^ upd_s2_q;
    assign rsp        = outst_q & tick_valid_i;
    assign last_frame = (f_q == FSEL_W'(FRAME_NUMBER_P - 1));
    assign last_col   = (col_q == ADDR_W'(FRAME_COLUMNS_P - 1));
    assign last_p     = (p_q == ADDR_W'(LINE_POINTS_P - 1));

    // Each frame restarts from zero; a passage turnaround adds back the measured edge ticks.
    assign base_tick = (col_q == '0) ? '0 : last_q;
    assign corr_tick = (p_q == '0 && k_q != '0) ? edge_tick_q[f_q] : '0;
    assign delta     = tick_i - base_tick + corr_tick;

`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
    assign active = mask_q[col_q];
`else
    assign active = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (req) state_d = S_EDGE;
            S_EDGE:   if (rsp && last_frame) state_d = S_UPDATE;
            S_UPDATE: if (last_wr_q) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_updated_o = (state_q == S_IDLE);
        done_o        = (state_q == S_DONE);
        theta_o       = '0;
        if (state_q == S_EDGE)
            theta_o = THETA_W'(TOTAL - FRAME_NUMBER_P + int'(f_q));
        else if (state_q == S_UPDATE)
            theta_o = THETA_W'(int'(p_q) * STEP + int'(k_q >> 1) * FRAME_NUMBER_P + int'(f_q));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            upd_s1_q  <= 1'b0;
            upd_s2_q  <= 1'b0;
            vld_q     <= 1'b0;
            outst_q   <= 1'b0;
            kick_q    <= 1'b0;
            last_wr_q <= 1'b0;
            f_q       <= '0;
            col_q     <= '0;
            p_q       <= '0;
            k_q       <= '0;
            last_q    <= '0;
            for (int i = 0; i < EDGE_N; i++) edge_tick_q[i] <= '0;
            we_q      <= 1'b0;
            overrun_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            msel_q    <= '0;
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            upd_s1_q <= update_mem_i;
            upd_s2_q <= upd_s1_q;
            we_q     <= 1'b0;
            kick_q   <= (state_d != state_q) && (state_d == S_EDGE || state_d == S_UPDATE);
            if (req && state_q != S_IDLE) overrun_q <= 1'b1;

            if (vld_q && theta_ready_i) begin
                vld_q   <= 1'b0;
                outst_q <= 1'b1;
            end else if (tick_valid_i) begin
                outst_q <= 1'b0;
            end
            if (kick_q) vld_q <= 1'b1;

            if (state_q == S_IDLE && req) begin
                f_q       <= '0;
                col_q     <= '0;
                p_q       <= '0;
                k_q       <= '0;
                last_wr_q <= 1'b0;
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
                mask_q    <= pixel_mask_i;
`endif
            end

            if (rsp && state_q == S_EDGE) begin
                edge_tick_q[f_q] <= tick_i;
                if (last_frame) f_q <= '0;
                else begin
                    f_q   <= f_q + 1'b1;
                    vld_q <= 1'b1;
                end
            end

            if (rsp && state_q == S_UPDATE) begin
                we_q    <= 1'b1;
                waddr_q <= col_q;
                msel_q  <= f_q;
                wdata_q <= {active, delta};
                last_q  <= tick_i;
                if (last_col) begin
                    col_q <= '0;
                    p_q   <= '0;
                    k_q   <= '0;
                    f_q   <= last_frame ? '0 : f_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                    p_q   <= last_p ? '0 : p_q + 1'b1;
                    k_q   <= last_p ? k_q + 1'b1 : k_q;
                end
                if (last_col && last_frame) last_wr_q <= 1'b1;
                else                        vld_q     <= 1'b1;
            end
        end
    end

    assign theta_valid_o = vld_q;
    assign we_o          = we_q;
    assign waddr_o       = waddr_q;
    assign wdata_o       = wdata_q;
    assign mem_sel_o     = msel_q;
    assign overrun_o     = overrun_q;
endmodule

// File: tb/tb_laser_tick_table_gen.sv
// Bench for laser_tick_table_gen: CORDIC responder, spec-level table model, fixed vectors plus random jobs.
module tb_laser_tick_table_gen;
    localparam int COLS  = 8;
    localparam int LP    = 4;
    localparam int FR    = 2;
    localparam int TW    = 8;
    localparam int STEP  = FR * (COLS / LP);
    localparam int TOTAL = COLS * FR;

    logic          clk_i = 1'b0;
    logic          rst_i, update_mem_i;
    logic          theta_valid_o, theta_ready_i, tick_valid_i;
    logic [3:0]    theta_o;
    logic [TW-1:0] tick_i;
    logic          we_o, mem_updated_o, done_o, overrun_o;
    logic [2:0]    waddr_o;
    logic [TW:0]   wdata_o;
    logic [0:0]    mem_sel_o;
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
    logic [COLS-1:0] pixel_mask_i;
`endif

    always #5 clk_i = ~clk_i;

    laser_tick_table_gen #(
        .FRAME_COLUMNS_P(COLS), .LINE_POINTS_P(LP), .FRAME_NUMBER_P(FR), .TICK_W_P(TW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .update_mem_i(update_mem_i),
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
        .pixel_mask_i(pixel_mask_i),
`endif
        .theta_valid_o(theta_valid_o), .theta_o(theta_o), .theta_ready_i(theta_ready_i),
        .tick_valid_i(tick_valid_i), .tick_i(tick_i), .we_o(we_o), .waddr_o(waddr_o),
        .wdata_o(wdata_o), .mem_sel_o(mem_sel_o), .mem_updated_o(mem_updated_o),
        .done_o(done_o), .overrun_o(overrun_o)
    );

    typedef struct {int sel; int addr; int dat;} wr_t;
    typedef struct {int mode; int sel; int addr; int dat;} vec_t;

    int  n_chk = 0, n_fail = 0;
    int  tick_mode = 0;
    bit  rand_ready = 0, force_ready = 1, spur_en = 0, rand_lat = 0;
    int  rnd_tab [TOTAL];
    logic [COLS-1:0] mask_v = '1;
    wr_t got_q[$];
    wr_t exp_q[$];
    int  done_cnt = 0;
    vec_t vec_tab [21];

    // responder-private state
    bit  pend = 0, prev_stall = 0;
    int  cnt = 0, th = 0;
    logic [3:0] prev_theta = '0;

    task automatic check(input string name, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic int tickf(input int t);
        int r;
        case (tick_mode)
            0:       r = 10 * t;
            1:       r = (200 + 60 * t) % 256;
            default: r = rnd_tab[t];
        endcase
        return r & ((1 << TW) - 1);
    endfunction

    // Reference: walk frames/columns directly from the theta and delta rules.
    task automatic build_exp();
        exp_q.delete();
        for (int f = 0; f < FR; f++) begin
            int prev;
            prev = 0;
            for (int col = 0; col < COLS; col++) begin
                int p, k, t, e, d, act;
                p   = col % LP;
                k   = col / LP;
                t   = tickf(p * STEP + (k / 2) * FR + f);
                e   = tickf(TOTAL - FR + f);
                d   = (t - prev + ((p == 0 && k > 0) ? e : 0)) & ((1 << TW) - 1);
                prev = t;
                act = int'(mask_v[col]);
                exp_q.push_back('{f, col, (act << TW) | d});
            end
        end
    endtask

    // CORDIC model: 2+ cycle latency, optional random ready / latency / stray strobes.
    initial begin
        theta_ready_i = 1'b0;
        tick_valid_i  = 1'b0;
        tick_i        = '0;
        forever begin
            @(negedge clk_i);
            tick_valid_i = 1'b0;
            if (rst_i) begin
                pend       = 0;
                prev_stall = 0;
            end else begin
                if (pend) begin
                    if (cnt == 0) begin
                        tick_valid_i = 1'b1;
                        tick_i       = TW'(tickf(th));
                        pend         = 0;
                    end else cnt--;
                end else if (spur_en && ($urandom % 8) == 0) begin
                    tick_valid_i = 1'b1;
                    tick_i       = TW'($urandom);
                end
                if (prev_stall)
                    check("theta_hold", {theta_valid_o, theta_o}, {1'b1, prev_theta});
                theta_ready_i = rand_ready ? 1'($urandom % 2) : force_ready;
                prev_stall = theta_valid_o && !theta_ready_i;
                prev_theta = theta_o;
                if (theta_valid_o && theta_ready_i && !pend) begin
                    pend = 1;
                    th   = int'(theta_o);
                    cnt  = (rand_lat ? 2 + int'($urandom % 4) : 2) - 1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (we_o) got_q.push_back('{int'(mem_sel_o), int'(waddr_o), int'(wdata_o)});
            if (done_o) done_cnt++;
        end
    end

    task automatic compare_job(input string tag);
        check({tag, " count"}, got_q.size(), TOTAL);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s wr%0d", tag, i),
                  got_q[i].sel * 100000 + got_q[i].addr * 1000 + got_q[i].dat,
                  exp_q[i].sel * 100000 + exp_q[i].addr * 1000 + exp_q[i].dat);
    endtask

    task automatic check_table(input int mode);
        for (int i = 0; i < 21; i++) begin
            if (vec_tab[i].mode == mode) begin
                int idx;
                idx = vec_tab[i].sel * COLS + vec_tab[i].addr;
                if (idx < got_q.size())
                    check($sformatf("tab m%0d f%0d c%0d", mode, vec_tab[i].sel, vec_tab[i].addr),
                          got_q[idx].sel * 100000 + got_q[idx].addr * 1000 + got_q[idx].dat,
                          vec_tab[i].sel * 100000 + vec_tab[i].addr * 1000 + vec_tab[i].dat);
                else
                    check($sformatf("tab m%0d f%0d c%0d missing", mode, vec_tab[i].sel, vec_tab[i].addr),
                          -1, vec_tab[i].dat);
            end
        end
    endtask

    task automatic run_job(input string tag, input int stall_at, input bit do_ovr);
        bit stalled, tog, seen;
        int dsz;
        stalled = 0; tog = 0; seen = 0; dsz = -1;
        got_q.delete();
        done_cnt = 0;
        build_exp();
        @(negedge clk_i);
        update_mem_i = ~update_mem_i;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(negedge clk_i);
            if (c == 4) check({tag, " busy mem_updated"}, mem_updated_o, 0);
            if (stall_at >= 0 && !stalled && got_q.size() == stall_at) begin
                stalled = 1;
                force_ready = 0;
                repeat (5) @(negedge clk_i);
                check({tag, " stall valid"}, theta_valid_o, 1);
                force_ready = 1;
            end
            if (do_ovr && !tog && got_q.size() == 6) begin
                tog = 1;
                update_mem_i = ~update_mem_i;
            end
            if (done_o) begin
                seen = 1;
                dsz  = got_q.size();
            end
        end
        check({tag, " done seen"}, seen, 1);
        check({tag, " writes before done"}, dsz, TOTAL);
        repeat (3) @(negedge clk_i);
        check({tag, " done pulses"}, done_cnt, 1);
        check({tag, " idle mem_updated"}, mem_updated_o, 1);
        compare_job(tag);
    endtask

    initial begin
        int d0 [16];
        bit hit;
        d0 = '{0, 40, 40, 40, 20, 40, 40, 40, 10, 40, 40, 40, 30, 40, 40, 40};
        for (int i = 0; i < 16; i++) vec_tab[i] = '{0, i / COLS, i % COLS, 256 + d0[i]};
        vec_tab[16] = '{1, 0, 0, 256 + 200};
        vec_tab[17] = '{1, 0, 1, 256 + 240};
        vec_tab[18] = '{1, 0, 4, 256 + 64};
        vec_tab[19] = '{1, 1, 0, 256 + 4};
        vec_tab[20] = '{1, 1, 4, 256 + 124};
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
        pixel_mask_i = mask_v;
`endif

        rst_i = 1'b1;
        update_mem_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check("reset mem_updated", mem_updated_o, 1);
        check("reset we", we_o, 0);
        check("reset theta_valid", theta_valid_o, 0);
        check("reset done", done_o, 0);
        check("reset overrun", overrun_o, 0);
        check("reset wdata", wdata_o, 0);

        tick_mode = 0;
        run_job("basic", -1, 0);
        check_table(0);

        run_job("stall", 3, 0);
        check_table(0);

        tick_mode = 1;
        run_job("wrap", -1, 0);
        check_table(1);

        tick_mode = 0;
        check("pre overrun", overrun_o, 0);
        run_job("overrun", -1, 1);
        check("overrun set", overrun_o, 1);
        repeat (30) @(negedge clk_i);
        check("overrun no second job writes", got_q.size(), TOTAL);
        check("overrun no second done", done_cnt, 1);
        check("overrun sticky", overrun_o, 1);
        check("overrun idle", mem_updated_o, 1);

        // Abort mid-job with reset after the 5th write.
        got_q.delete();
        @(negedge clk_i);
        update_mem_i = ~update_mem_i;
        hit = 0;
        for (int c = 0; c < 2000 && !hit; c++) begin
            @(negedge clk_i);
            if (got_q.size() >= 5) hit = 1;
        end
        check("abort reached 5 writes", got_q.size(), 5);
        rst_i = 1'b1;
        update_mem_i = 1'b0;
        @(negedge clk_i);
        check("abort mem_updated", mem_updated_o, 1);
        check("abort we", we_o, 0);
        check("abort theta_valid", theta_valid_o, 0);
        check("abort done", done_o, 0);
        check("abort overrun cleared", overrun_o, 0);
        rst_i = 1'b0;
        got_q.delete();
        done_cnt = 0;
        repeat (20) @(negedge clk_i);
        check("abort no writes", got_q.size(), 0);
        check("abort no done", done_cnt, 0);
        run_job("after reset", -1, 0);
        check_table(0);

        tick_mode  = 2;
        rand_ready = 1;
        spur_en    = 1;
        rand_lat   = 1;
        for (int j = 0; j < 4; j++) begin
            for (int t = 0; t < TOTAL; t++) rnd_tab[t] = int'($urandom_range(0, 255));
`ifdef LASER_TICK_TABLE_PIXEL_MASK_EN
            mask_v = COLS'($urandom);
            pixel_mask_i = mask_v;
`endif
            run_job($sformatf("rand%0d", j), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
